// File: rtl/twiddle_loader.sv
// twiddle_loader
//   Rebuilds the real and imaginary twiddle tables in RAM from a byte stream,
//   normally the UART receiver. The SDFT table reader fetches from that RAM,
//   so tables can be replaced at runtime.
//
//   Frame format: SYNC_BYTE, then 2*N little-endian words (N = 2**addr_w).
//   Words 0..N-1 go to the real table and words N..2N-1 to the imaginary
//   table. Each word is BPW bytes: 1 if data_w <= 8, otherwise 2.
//
//   Optional feature, controlled by the macro TWIDDLE_LOADER_CHECKSUM_EN:
//   a single checksum byte follows the last word. It must equal the 8-bit sum
//   of all data bytes. A match gives done and a mismatch gives error. Without
//   the macro the frame ends on its last word and error stays 0.
//
//   Handshake: a byte transfers on a rising edge where in_valid & in_ready.
//   in_ready depends only on the state and on reset, never on in_valid. It is
//   high in IDLE, LOAD and CHECK. It is low in DONE, in ERR and while reset is
//   asserted.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   in_data/in_valid  stream byte and its valid flag
//   in_ready          loader can accept a byte
//   wr_en             one-cycle RAM write strobe
//   wr_sel            0 = real table, 1 = imaginary table
//   wr_addr, wr_data  table address and coefficient of the write
//   busy              frame in progress (sync accepted, frame not finished)
//   done, error       one-cycle pulses that end a frame
//   dbg_state         current FSM state, for observation only

module twiddle_loader #(
  parameter int          addr_w    = 7,
  parameter int          data_w    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [addr_w-1:0] wr_addr,
  output logic [data_w-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  localparam int BPW = (data_w <= 8) ? 1 : 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              r_state;
  // The MSB selects the table and the low bits address the word in it.
  logic [addr_w:0]     r_word_cnt;
  logic                r_byte_idx;   // 1 = low byte of a 2-byte word is held
  logic [7:0]          r_lo_byte;
  logic                r_wr_en;
  logic                r_wr_sel;
  logic [addr_w-1:0]   r_wr_addr;
  logic [data_w-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_error;
`endif

  logic                w_accept;
  logic                w_word_last_byte;
  logic                w_last_word;
  logic [data_w-1:0]   w_word;

  assign in_ready = !reset &&
                    (r_state == S_IDLE || r_state == S_LOAD || r_state == S_CHECK);
  assign w_accept = in_valid && in_ready;

  // With 1-byte words, every byte completes a word.
  assign w_word_last_byte = (BPW == 1) ? 1'b1 : r_byte_idx;
  assign w_last_word      = &r_word_cnt;
  // Little-endian assembly. Bits above data_w are dropped.
  assign w_word = (BPW == 2) ? data_w'({in_data, r_lo_byte})
                             : data_w'({8'h00, in_data});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_byte_idx <= 1'b0;
      r_lo_byte  <= 8'h00;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
      r_sum      <= 8'h00;
      r_error    <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // Bytes other than SYNC_BYTE are dropped while hunting for a frame.
          if (w_accept && in_data == SYNC_BYTE) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_word_cnt <= '0;
            r_byte_idx <= 1'b0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
          end
        end

        S_LOAD: begin
          if (w_accept) begin
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
            if (w_word_last_byte) begin
              r_wr_en    <= 1'b1;
              r_wr_sel   <= r_word_cnt[addr_w];
              r_wr_addr  <= r_word_cnt[addr_w-1:0];
              r_wr_data  <= w_word;
              r_word_cnt <= r_word_cnt + 1'b1;
              r_byte_idx <= 1'b0;
              if (w_last_word) begin
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                // The last word's wr_en and done appear in the same cycle.
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
`endif
              end
            end else begin
              r_lo_byte  <= in_data;
              r_byte_idx <= 1'b1;
            end
          end
        end

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (in_data == r_sum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERR: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
  assign error     = r_error;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_twiddle_loader.sv
// tb_twiddle_loader
//   Bench for twiddle_loader. The main instance uses addr_w=2 (N=4) and
//   data_w=8. A second instance uses data_w=12 to cover 2-byte words.
//
//   A frame-level model predicts the outputs for every cycle from the bytes
//   offered. Inputs change 1 time unit after a rising edge. The model and the
//   checks run on the falling edge.

module tb_twiddle_loader;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int BPW = 1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  logic [7:0]    t_in_data;
  logic          t_in_valid;
  logic          t_in_ready;
  logic          t_wr_en;
  logic          t_wr_sel;
  logic [1:0]    t_wr_addr;
  logic [11:0]   t_wr_data;
  logic          t_busy;
  logic          t_done;
  logic          t_error;
  logic [2:0]    t_dbg_state;

  twiddle_loader #(.addr_w(AW), .data_w(DW), .SYNC_BYTE(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  twiddle_loader #(.addr_w(2), .data_w(12), .SYNC_BYTE(8'hA5)) u_dut12 (
    .clk(clk), .reset(reset), .in_data(t_in_data), .in_valid(t_in_valid),
    .in_ready(t_in_ready), .wr_en(t_wr_en), .wr_sel(t_wr_sel), .wr_addr(t_wr_addr),
    .wr_data(t_wr_data), .busy(t_busy), .done(t_done), .error(t_error),
    .dbg_state(t_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame model ----------------
  bit         m_in_frame   = 0;
  bit         m_cksum_wait = 0;
  bit         m_post       = 0;   // the one-cycle DONE/ERR slot
  int         m_sum        = 0;
  logic [7:0] m_bytes[$];
  bit         e_wr_en = 0, e_sel = 0, e_busy = 0, e_done = 0, e_error = 0;
  int         e_addr = 0, e_data = 0;

  // Observations of the DUT, checked against literals by the directed tests.
  int          cnt_wr = 0, cnt_done = 0, cnt_err = 0, cnt_done_wr = 0;
  logic [7:0]  real_mem[N];
  logic [7:0]  imag_mem[N];
  logic [10:0] wlog[$];

  always @(negedge clk) begin : model
    bit exp_ready;
    bit acc;
    int w;
    int val;
    exp_ready = !reset && !m_post;
    chk("in_ready", in_ready, exp_ready);
    if (reset) begin
      chk("wr_en_rst", wr_en, 0);
      chk("busy_rst", busy, 0);
      chk("done_rst", done, 0);
      chk("error_rst", error, 0);
    end else begin
      chk("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
        chk("wr_sel", wr_sel, e_sel);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("error", error, e_error);
    end

    if (wr_en) begin
      cnt_wr++;
      wlog.push_back({wr_sel, wr_addr, wr_data});
      if (wr_sel) imag_mem[wr_addr] = wr_data;
      else        real_mem[wr_addr] = wr_data;
    end
    if (done) cnt_done++;
    if (error) cnt_err++;
    if (done && wr_en) cnt_done_wr++;

    // Prediction for the cycle after the coming rising edge.
    e_wr_en = 0; e_done = 0; e_error = 0;
    if (reset) begin
      m_in_frame = 0; m_cksum_wait = 0; m_post = 0; e_busy = 0;
    end else begin
      acc = in_valid && exp_ready;
      if (m_post) begin
        m_post = 0;
      end else if (!m_in_frame) begin
        if (acc && in_data == 8'hA5) begin
          m_in_frame = 1; m_bytes.delete(); m_sum = 0; e_busy = 1;
        end
      end else if (m_cksum_wait) begin
        if (acc) begin
          if (int'(in_data) == m_sum % 256) e_done = 1;
          else e_error = 1;
          m_post = 1; m_in_frame = 0; m_cksum_wait = 0; e_busy = 0;
        end
      end else if (acc) begin
        m_bytes.push_back(in_data);
        m_sum += int'(in_data);
        if (m_bytes.size() % BPW == 0) begin
          w   = m_bytes.size() / BPW - 1;
          val = (BPW == 2) ? int'(m_bytes[2*w]) + 256 * int'(m_bytes[2*w+1])
                           : int'(in_data);
          e_wr_en = 1;
          e_sel   = (w >= N);
          e_addr  = w % N;
          e_data  = val % (1 << DW);
          if (w == 2*N - 1) begin
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            m_cksum_wait = 1;
`else
            e_done = 1; e_busy = 0; m_post = 1; m_in_frame = 0;
`endif
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Sends SYNC_BYTE and 8 data bytes, plus the checksum byte when the checksum
  // feature is built in. cks_delta adds a deliberate checksum error.
  task automatic send_frame(input logic [7:0] d[8], input int maxgap, input int cks_delta);
    int s;
    s = 0;
    send_byte(8'hA5, $urandom_range(maxgap, 0));
    for (int i = 0; i < 8; i++) begin
      send_byte(d[i], $urandom_range(maxgap, 0));
      s += int'(d[i]);
    end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    send_byte(8'((s + cks_delta) % 256), $urandom_range(maxgap, 0));
`else
    s = s + cks_delta;
`endif
  endtask

  task automatic clear_obs();
    cnt_wr = 0; cnt_done = 0; cnt_err = 0; cnt_done_wr = 0;
    wlog.delete();
    for (int i = 0; i < N; i++) begin
      real_mem[i] = 8'hxx;
      imag_mem[i] = 8'hxx;
    end
  endtask

  task automatic mid_clock_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_state", dbg_state, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_tables(input string tag, input logic [7:0] r[4], input logic [7:0] im[4]);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_real"}, real_mem[i], r[i]);
      chk({tag, "_imag"}, imag_mem[i], im[i]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq[8];
    logic [7:0] seq_a5[8];
    logic [7:0] r_exp[4];
    logic [7:0] i_exp[4];
    seq    = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    seq_a5 = '{8'h00, 8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA5, 8'h07};
    r_exp  = '{8'h00, 8'h01, 8'h02, 8'h03};
    i_exp  = '{8'h04, 8'h05, 8'h06, 8'h07};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    t_in_valid = 1'b0; t_in_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: reset state, then an asynchronous reset in the middle of a frame
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    send_byte(8'h11, 0);
    mid_clock_reset();
    clear_obs();
    repeat (3) tick();
    chk("t1_ready_after", in_ready, 1);
    chk("t1_no_write", cnt_wr, 0);

    // 2: a stray byte before the sync, then a clean frame
    clear_obs();
    send_byte(8'h11, 0);
    send_frame(seq, 0, 0);
    repeat (4) tick();
    chk("t2_writes", cnt_wr, 8);
    chk("t2_done", cnt_done, 1);
    chk("t2_err", cnt_err, 0);
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    chk("t2_done_with_wr", cnt_done_wr, 0);
`else
    chk("t2_done_with_wr", cnt_done_wr, 1);
`endif
    chk("t2_first_write", wlog[0], 11'h000);
    chk("t2_last_write", wlog[7], {1'b1, 2'd3, 8'h07});
    check_tables("t2", r_exp, i_exp);

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    // 3: good checksum (1C), then bad checksum (1D)
    clear_obs();
    send_frame(seq, 0, 0);
    repeat (4) tick();
    chk("t3_done", cnt_done, 1);
    chk("t3_err", cnt_err, 0);
    clear_obs();
    send_frame(seq, 0, 1);
    repeat (4) tick();
    chk("t3b_done", cnt_done, 0);
    chk("t3b_err", cnt_err, 1);
    chk("t3b_writes", cnt_wr, 8);
    chk("t3b_idle", dbg_state, 0);
`endif

    // 5: reset after 3 words, then a full frame starts again at real addr 0
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h21, 0);
    send_byte(8'h22, 0);
    mid_clock_reset();
    clear_obs();
    chk("t5_busy_idle", busy, 0);
    send_frame(seq, 0, 0);
    repeat (4) tick();
    chk("t5_first_write", wlog[0], 11'h000);
    chk("t5_writes", cnt_wr, 8);
    chk("t5_done", cnt_done, 1);

    // 6: random 0-5 cycle gaps; A5 inside the frame is data
    clear_obs();
    send_frame(seq, 5, 0);
    repeat (4) tick();
    chk("t6_writes", cnt_wr, 8);
    chk("t6_done", cnt_done, 1);
    check_tables("t6", r_exp, i_exp);
    clear_obs();
    send_frame(seq_a5, 5, 0);
    repeat (4) tick();
    chk("t6b_writes", cnt_wr, 8);
    chk("t6b_done", cnt_done, 1);
    chk("t6b_real1", real_mem[1], 8'hA5);
    chk("t6b_imag2", imag_mem[2], 8'hA5);

    // 4: data_w=12, little-endian pair 34,12 -> 12'h234
    chk("t4_idle_ready", t_in_ready, 1);
    t_in_valid = 1'b1; t_in_data = 8'hA5; tick();
    t_in_data = 8'h34; tick();
    chk("t4_no_early_wr", t_wr_en, 0);
    t_in_data = 8'h12; tick();
    t_in_valid = 1'b0;
    chk("t4_wr_en", t_wr_en, 1);
    chk("t4_wr_sel", t_wr_sel, 0);
    chk("t4_wr_addr", t_wr_addr, 0);
    chk("t4_wr_data", t_wr_data, 12'h234);
    chk("t4_busy", t_busy, 1);
    tick();
    chk("t4_wr_pulse", t_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
